// File: rtl/fb_pkg.sv
// Shared types and constants for the frame buffer pixel writer.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT    = 2'd0,
        ST_WRITE_DATA = 2'd1,
        ST_WRITE_CMD  = 2'd2
    } fb_state_e;

    localparam int PIXELS_PER_BURST = 8;
    localparam int BEATS_PER_BURST  = 2;
    localparam int PIXELS_PER_BEAT  = PIXELS_PER_BURST / BEATS_PER_BURST;

    localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;

endpackage

// File: rtl/defines.svh
// Frame buffer geometry shared by the writer and its bench.
`ifndef FB_DEFINES_SVH
`define FB_DEFINES_SVH

`ifndef FB_ADDR_WIDTH
`define FB_ADDR_WIDTH 12
`endif

`ifndef FB_MAX_ADDR
`define FB_MAX_ADDR 128
`endif

`endif

// File: rtl/fb_pixel_writer_pixel_packer.sv
// Packs up to 8 RGB444 pixels into a burst and muxes out one 64-bit beat.
module pixel_packer
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [11:0] i_rgb,
    input  logic        i_beat_sel,
    output logic [2:0]  o_index,
    output logic [63:0] o_beat
);

    logic [15:0] r_slot [PIXELS_PER_BURST];
    logic [2:0]  r_index;
    logic [2:0]  w_base;

    // Clearing after every command leaves unfilled slots zero for short flushes
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < PIXELS_PER_BURST; i++) begin
                r_slot[i] <= '0;
            end
            r_index <= '0;
        end else if (i_push) begin
            r_slot[r_index] <= {4'h0, i_rgb};
            r_index         <= r_index + 3'd1;
        end
    end

    assign w_base  = i_beat_sel ? 3'(PIXELS_PER_BEAT) : 3'd0;
    assign o_index = r_index;

    always_comb begin
        o_beat = '0;
        for (int k = 0; k < PIXELS_PER_BEAT; k++) begin
            o_beat[16*k +: 16] = r_slot[w_base + 3'(k)];
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Renderer-to-DDR3 pixel writer: 8-pixel bursts, 2 beats + 1 write command.
// Optional FB_WR_PERF_EN adds a saturating stall_count output.
`include "defines.svh"

module fb_pixel_writer
    import fb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [15:0]               pix_data,
    input  logic                      pix_last,
    input  logic                      ddr3_app_rdy,
    input  logic                      ddr3_app_wdf_rdy,
    output logic                      ddr3_app_en,
    output logic [2:0]                ddr3_app_cmd,
    output logic [`FB_ADDR_WIDTH-1:0] ddr3_app_addr,
    output logic [63:0]               ddr3_app_wdf_data,
    output logic                      ddr3_app_wdf_wren,
    output logic                      ddr3_app_wdf_end,
    output logic                      render_complete
`ifdef FB_WR_PERF_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    localparam int AW = `FB_ADDR_WIDTH;
    localparam logic [AW-1:0] LAST_BASE = AW'(`FB_MAX_ADDR - 8);
    localparam logic [AW-1:0] STRIDE    = AW'(PIXELS_PER_BURST);

    fb_state_e   r_state;
    logic [AW-1:0] r_addr;
    logic        r_beat_sel;
    logic        r_last;
    logic        r_app_en;
    logic        r_wren;
    logic        r_wdf_end;
    logic        r_done;

    logic        w_accept;
    logic        w_flush;
    logic        w_cmd_done;
    logic [2:0]  w_index;
    logic [63:0] w_beat;
    logic        w_unused;

    assign w_accept   = pix_valid && (r_state == ST_COLLECT);
    assign w_flush    = w_accept && (pix_last || (w_index == 3'd7));
    assign w_cmd_done = (r_state == ST_WRITE_CMD) && ddr3_app_rdy;
    assign w_unused   = ^pix_data[15:12];

    pixel_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cmd_done),
        .i_push     (w_accept),
        .i_rgb      (pix_data[11:0]),
        .i_beat_sel (r_beat_sel),
        .o_index    (w_index),
        .o_beat     (w_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_addr     <= '0;
            r_beat_sel <= 1'b0;
            r_last     <= 1'b0;
            r_app_en   <= 1'b0;
            r_wren     <= 1'b0;
            r_wdf_end  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_COLLECT: begin
                    if (w_flush) begin
                        r_state    <= ST_WRITE_DATA;
                        r_wren     <= 1'b1;
                        r_wdf_end  <= 1'b0;
                        r_beat_sel <= 1'b0;
                        r_last     <= pix_last;
                    end
                end
                ST_WRITE_DATA: begin
                    if (ddr3_app_wdf_rdy) begin
                        if (!r_beat_sel) begin
                            r_beat_sel <= 1'b1;
                            r_wdf_end  <= 1'b1;
                        end else begin
                            r_wren    <= 1'b0;
                            r_wdf_end <= 1'b0;
                            r_app_en  <= 1'b1;
                            r_state   <= ST_WRITE_CMD;
                        end
                    end
                end
                ST_WRITE_CMD: begin
                    if (ddr3_app_rdy) begin
                        r_app_en   <= 1'b0;
                        r_beat_sel <= 1'b0;
                        r_state    <= ST_COLLECT;
                        // A frame end restarts the buffer at 0
                        if (r_last) begin
                            r_addr <= '0;
                            r_last <= 1'b0;
                            r_done <= 1'b1;
                        end else if (r_addr == LAST_BASE) begin
                            r_addr <= '0;
                        end else begin
                            r_addr <= r_addr + STRIDE;
                        end
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

`ifdef FB_WR_PERF_EN
    logic [31:0] r_stall_count;
    logic        w_stall;

    assign w_stall = (r_wren && !ddr3_app_wdf_rdy) ||
                     (r_app_en && !ddr3_app_rdy);

    always_ff @(posedge clk) begin
        if (rst || r_done) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign pix_ready         = (r_state == ST_COLLECT);
    assign ddr3_app_en       = r_app_en;
    assign ddr3_app_cmd      = DDR3_CMD_WRITE;
    assign ddr3_app_addr     = r_addr;
    assign ddr3_app_wdf_data = w_beat;
    assign ddr3_app_wdf_wren = r_wren;
    assign ddr3_app_wdf_end  = r_wdf_end;
    assign render_complete   = r_done;

endmodule
